// File: rtl/aoi_pkg.sv
// rtl/aoi_pkg.sv - shared types and default constants for the AOI input debounce stage
package aoi_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

  localparam int AOI_WIDTH           = 4;
  localparam int AOI_SYNC_STAGES     = 2;
  localparam int AOI_DEBOUNCE_CYCLES = 16;
  localparam int AOI_GLITCH_CNT_W    = 8;

endpackage

// File: rtl/aoi_debounce_chan.sv
// rtl/aoi_debounce_chan.sv - single-bit synchroniser, debounce FSM/counter and edge pulse flops
module aoi_debounce_chan
  import aoi_pkg::*;
#(
  parameter int SYNC_STAGES     = AOI_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = AOI_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic stable_next,
  output logic bounce
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  deb_state_t             r_state;
  deb_state_t             w_state_nxt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_differ;
  logic                   w_cnt_done;
  logic                   w_accept;
  logic                   w_bounce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
  end

  assign w_differ   = (r_sync[SYNC_STAGES-1] != r_clean);
  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_STABLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STABLE:  if (w_differ) w_state_nxt = ST_PENDING;
      ST_PENDING: if (!w_differ || w_cnt_done) w_state_nxt = ST_STABLE;
      default:    w_state_nxt = ST_STABLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_bounce = 1'b0;
    if (r_state == ST_PENDING) begin
      w_accept = w_differ && w_cnt_done;
      w_bounce = !w_differ;
    end
  end

  // Counter holds the number of consecutive differing samples seen so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (w_state_nxt != ST_PENDING)  r_cnt <= '0;
    else if (r_state == ST_STABLE)       r_cnt <= CNT_W'(1);
    else                                 r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_accept & ~r_clean;
      r_fall <= w_accept &  r_clean;
      if (w_accept) r_clean <= ~r_clean;
    end
  end

  assign clean_out   = r_clean;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign stable_next = (w_state_nxt == ST_STABLE);
  assign bounce      = w_bounce;

endmodule

// File: rtl/aoi_input_debounce.sv
// rtl/aoi_input_debounce.sv - per-channel debounce array with all-settled flag
// Optional bounce-back counter output enabled by AOI_DEBOUNCE_GLITCH_CNT_EN.
module aoi_input_debounce
  import aoi_pkg::*;
#(
  parameter int WIDTH           = AOI_WIDTH,
  parameter int SYNC_STAGES     = AOI_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = AOI_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
`ifdef AOI_DEBOUNCE_GLITCH_CNT_EN
  output logic [AOI_GLITCH_CNT_W-1:0] glitch_count,
`endif
  output logic             stable
);

  logic [WIDTH-1:0] w_stable_next;
  logic [WIDTH-1:0] w_bounce;
  logic             r_stable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    aoi_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in[i]),
      .clean_out  (clean_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .stable_next(w_stable_next[i]),
      .bounce     (w_bounce[i])
    );
  end

  // Registering the reduction of next states makes stable track the current states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stable <= 1'b1;
    else        r_stable <= &w_stable_next;
  end

  assign stable = r_stable;

`ifdef AOI_DEBOUNCE_GLITCH_CNT_EN
  localparam int GSUM_W = AOI_GLITCH_CNT_W + $clog2(WIDTH + 1);

  logic [AOI_GLITCH_CNT_W-1:0] r_glitch;
  logic [GSUM_W-1:0]           w_glitch_sum;

  always_comb begin
    w_glitch_sum = GSUM_W'(r_glitch);
    for (int i = 0; i < WIDTH; i++) w_glitch_sum = w_glitch_sum + GSUM_W'(w_bounce[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_glitch <= '0;
    else if (w_glitch_sum > GSUM_W'({AOI_GLITCH_CNT_W{1'b1}})) r_glitch <= '1;
    else                                                 r_glitch <= w_glitch_sum[AOI_GLITCH_CNT_W-1:0];
  end

  assign glitch_count = r_glitch;
`else
  logic w_unused_bounce;
  assign w_unused_bounce = ^w_bounce;
`endif

endmodule

// File: tb/tb_aoi_input_debounce.sv
// tb/tb_aoi_input_debounce.sv - self-checking bench with sliding-window reference model
module tb_aoi_input_debounce;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clean_out, rise_pulse, fall_pulse;
  logic         stable;
`ifdef AOI_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]   glitch_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;
  logic [W-1:0] pulse_seen = '0;

  always #5 clk = ~clk;

  aoi_input_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
`ifdef AOI_DEBOUNCE_GLITCH_CNT_EN
    .glitch_count(glitch_count),
`endif
    .stable    (stable)
  );

  // Reference: a level is accepted once the last D values seen after the
  // synchroniser all disagree with the current clean level.
  logic [W-1:0] m_sync [S];
  logic [D-1:0] m_win  [W];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_stable;
  int           m_glitch;

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] seen, nc, nr, nf;
    logic [D-1:0] w;
    logic         all_st;
    int           g;
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_sync[k] <= '0;
      for (int c = 0; c < W; c++) m_win[c] <= '0;
      m_clean  <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_stable <= 1'b1;
      m_glitch <= 0;
    end else begin
      seen = m_sync[S-1];
      nc = m_clean; nr = '0; nf = '0; all_st = 1'b1; g = 0;
      for (int c = 0; c < W; c++) begin
        w = {m_win[c][D-2:0], seen[c]};
        if (w == {D{~m_clean[c]}}) begin
          nc[c] = ~m_clean[c];
          nr[c] = nc[c];
          nf[c] = ~nc[c];
        end else if (m_win[c][0] != m_clean[c] && w[0] == m_clean[c]) begin
          g++;
        end
        if (w[0] != nc[c]) all_st = 1'b0;
        m_win[c] <= w;
      end
      for (int k = S - 1; k > 0; k--) m_sync[k] <= m_sync[k-1];
      m_sync[0] <= raw_in;
      m_clean  <= nc;
      m_rise   <= nr;
      m_fall   <= nf;
      m_stable <= all_st;
      m_glitch <= (m_glitch + g > 255) ? 255 : m_glitch + g;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_clean", 32'(clean_out), 32'(m_clean));
      chk("model_rise",  32'(rise_pulse), 32'(m_rise));
      chk("model_fall",  32'(fall_pulse), 32'(m_fall));
      chk("model_stable", 32'(stable), 32'(m_stable));
`ifdef AOI_DEBOUNCE_GLITCH_CNT_EN
      chk("model_glitch", 32'(glitch_count), 32'(m_glitch));
`endif
      pulse_seen = pulse_seen | rise_pulse | fall_pulse;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    rst_n = 1'b0;
    raw_in = v;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset values, then all inputs high from release
    raw_in = 4'hF;
    #1 rst_n = 1'b0;
    tick(1);
    cmp_en = 1'b1;
    chk("rst_clean", 32'(clean_out), 32'h0);
    chk("rst_rise",  32'(rise_pulse), 32'h0);
    chk("rst_fall",  32'(fall_pulse), 32'h0);
    chk("rst_stable", 32'(stable), 32'h1);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("t1_stable_pending", 32'(stable), 32'h0);
    tick(2);
    chk("t1_clean_edge5", 32'(clean_out), 32'h0);
    tick(1);
    chk("t1_clean_edge6", 32'(clean_out), 32'hF);
    chk("t1_rise_edge6",  32'(rise_pulse), 32'hF);
    chk("t1_stable_edge6", 32'(stable), 32'h1);
    tick(1);
    chk("t1_rise_edge7", 32'(rise_pulse), 32'h0);

    // 2: single channel rise
    do_reset(4'h0);
    raw_in = 4'h1;
    tick(2);
    chk("t2_stable_edge2", 32'(stable), 32'h1);
    tick(1);
    chk("t2_stable_edge3", 32'(stable), 32'h0);
    tick(2);
    chk("t2_clean_edge5", 32'(clean_out), 32'h0);
    tick(1);
    chk("t2_clean_edge6", 32'(clean_out), 32'h1);
    chk("t2_rise_edge6",  32'(rise_pulse), 32'h1);
    chk("t2_stable_edge6", 32'(stable), 32'h1);
    tick(1);
    chk("t2_rise_edge7", 32'(rise_pulse), 32'h0);

    // 3: two-cycle glitch on channel 1
    do_reset(4'h0);
    pulse_seen = '0;
    raw_in = 4'h2;
    tick(2);
    raw_in = 4'h0;
    tick(1);
    chk("t3_stable_pending", 32'(stable), 32'h0);
    tick(2);
    chk("t3_stable_back", 32'(stable), 32'h1);
    tick(8);
    chk("t3_clean", 32'(clean_out), 32'h0);
    chk("t3_no_pulse", 32'(pulse_seen), 32'h0);
`ifdef AOI_DEBOUNCE_GLITCH_CNT_EN
    chk("t3_glitch_count", 32'(glitch_count), 32'h1);
`endif

    // 4: simultaneous rise then fall on channels 1 and 3
    do_reset(4'h0);
    raw_in = 4'hA;
    tick(5);
    chk("t4_clean_edge5", 32'(clean_out), 32'h0);
    tick(1);
    chk("t4_clean_edge6", 32'(clean_out), 32'hA);
    chk("t4_rise_edge6",  32'(rise_pulse), 32'hA);
    chk("t4_fall_edge6",  32'(fall_pulse), 32'h0);
    raw_in = 4'h0;
    tick(6);
    chk("t4_clean_fall", 32'(clean_out), 32'h0);
    chk("t4_fall_pulse", 32'(fall_pulse), 32'hA);
    chk("t4_rise_none",  32'(rise_pulse), 32'h0);

    // 5: bounce restarts the count on channel 2
    do_reset(4'h0);
    raw_in = 4'h4; tick(1);
    raw_in = 4'h4; tick(1);
    raw_in = 4'h0; tick(1);
    raw_in = 4'h4; tick(1);
    tick(4);
    chk("t5_clean_edge8", 32'(clean_out), 32'h0);
    tick(1);
    chk("t5_clean_edge9", 32'(clean_out), 32'h4);
    chk("t5_rise_edge9",  32'(rise_pulse), 32'h4);

    // 6: reset while channel 3 is pending
    do_reset(4'h0);
    raw_in = 4'h8;
    tick(4);
    chk("t6_stable_pending", 32'(stable), 32'h0);
    rst_n = 1'b0;
    raw_in = 4'h0;
    #1;
    chk("t6_async_clean", 32'(clean_out), 32'h0);
    chk("t6_async_stable", 32'(stable), 32'h1);
    tick(2);
    rst_n = 1'b1;
    pulse_seen = '0;
    tick(12);
    chk("t6_no_pulse", 32'(pulse_seen), 32'h0);
    chk("t6_clean", 32'(clean_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
